// File: rtl/key_pio_debounced.sv
// Debounced key/switch input port with an Avalon-MM slave interface.
// Raw pins go through a synchroniser and a per-bit debounce filter. Edges
// of the debounced level are latched into a sticky capture register, and
// a maskable level interrupt is raised toward the processor.
module key_pio_debounced #(
    parameter int   WIDTH           = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1,
    parameter int   EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_LEVEL}};

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_stable_reg;
    logic [WIDTH-1:0] edge_capture_reg, edge_capture_next;
    logic [WIDTH-1:0] irq_mask_reg, irq_mask_next;
    logic [WIDTH-1:0] rise, fall, ev, clr;
    logic [31:0]      readdata_reg, readdata_next;
    logic             wr_en;
    logic             unused_writedata;

    // Only the low WIDTH bits of writedata are ever stored.
    assign unused_writedata = ^writedata;

    // Synchroniser: each stage reloads from the one before it, stage 0 from the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= IDLE_WORD;
            end
        end else begin
            sync_reg[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // One independent debounce filter per input bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic             stable_reg, stable_next;

        // Count consecutive cycles the synchronised level differs; accept on the last one.
        always_comb begin
            cnt_next    = cnt_reg;
            stable_next = stable_reg;
            if (sync_out[gi] == stable_reg) begin
                cnt_next = '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_next = sync_out[gi];
                cnt_next    = '0;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        // Filter state register; reset drops any half-finished count.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_reg    <= '0;
                stable_reg <= IDLE_LEVEL;
            end else begin
                cnt_reg    <= cnt_next;
                stable_reg <= stable_next;
            end
        end

        assign stable[gi] = stable_reg;
    end

    assign wr_en = chipselect & ~write_n;
    assign rise  = stable & ~prev_stable_reg;
    assign fall  = ~stable & prev_stable_reg;

    // Select the event polarity and build the capture/mask/read next values.
    always_comb begin
        ev                = '0;
        clr               = '0;
        irq_mask_next     = irq_mask_reg;
        readdata_next     = '0;
        case (EDGE_TYPE)
            0:       ev = rise;
            1:       ev = fall;
            default: ev = rise | fall;
        endcase
        if (wr_en && address == ADDR_EDGE) begin
            clr = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_MASK) begin
            irq_mask_next = writedata[WIDTH-1:0];
        end
        // A new event beats a simultaneous clear of the same bit.
        edge_capture_next = (edge_capture_reg & ~clr) | ev;
        case (address)
            ADDR_DATA: readdata_next[WIDTH-1:0] = stable;
            ADDR_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = edge_capture_reg;
            default:   readdata_next            = '0;
        endcase
    end

    // Edge history, capture, mask and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_stable_reg  <= IDLE_WORD;
            edge_capture_reg <= '0;
            irq_mask_reg     <= '0;
            readdata_reg     <= '0;
        end else begin
            prev_stable_reg  <= stable;
            edge_capture_reg <= edge_capture_next;
            irq_mask_reg     <= irq_mask_next;
            readdata_reg     <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_key_pio_debounced.sv
// Bench for key_pio_debounced: directed vector table, hand-written reset
// sequence, then random traffic checked against a window-based model.
module tb_key_pio_debounced;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int HL = S + D;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    key_pio_debounced #(
        .WIDTH(4),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D),
        .IDLE_LEVEL(1'b1),
        .EDGE_TYPE(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last D synchronised
    // samples all disagree with the current debounced level.
    logic [3:0]  hist_m [HL];
    logic [3:0]  st_m, pv_m, cap_m, mask_m;
    logic [31:0] rd_m;
    logic        irq_m;

    task automatic model_reset();
        for (int k = 0; k < HL; k++) hist_m[k] = 4'hF;
        st_m   = 4'hF;
        pv_m   = 4'hF;
        cap_m  = 4'h0;
        mask_m = 4'h0;
        rd_m   = 32'h0;
        irq_m  = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] inp, input logic [1:0] a,
                              input logic we, input logic [31:0] wd);
        logic [3:0] ev, clr, st_new;
        logic       all_diff;
        case (a)
            2'd0:    rd_m = {28'h0, st_m};
            2'd2:    rd_m = {28'h0, mask_m};
            2'd3:    rd_m = {28'h0, cap_m};
            default: rd_m = 32'h0;
        endcase
        ev  = pv_m & ~st_m;
        clr = (we && a == 2'd3) ? wd[3:0] : 4'h0;
        for (int k = HL - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = inp;
        st_new = st_m;
        for (int b = 0; b < 4; b++) begin
            all_diff = 1'b1;
            for (int k = S; k < HL; k++) begin
                if (hist_m[k][b] == st_m[b]) all_diff = 1'b0;
            end
            if (all_diff) st_new[b] = ~st_m[b];
        end
        pv_m  = st_m;
        cap_m = (cap_m & ~clr) | ev;
        if (we && a == 2'd2) mask_m = wd[3:0];
        st_m  = st_new;
        irq_m = |(cap_m & mask_m);
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Called at a falling edge; drives one bus cycle, checks against the model,
    // and returns at the next falling edge.
    task automatic cycle(input logic [3:0] inp, input logic [1:0] a, input logic cs,
                         input logic wn, input logic [31:0] wd);
        in_port    = inp;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
        model_edge(inp, a, cs && !wn, wd);
        #1;
        check32("model_readdata", readdata, rd_m);
        check1("model_irq", irq, irq_m);
        @(negedge clk);
    endtask

    // Cycle plus a check against hand-derived constants.
    task automatic cyc_chk(input string nm, input logic [3:0] inp, input logic [1:0] a,
                           input logic wr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_irq);
        cycle(inp, a, 1'b1, ~wr, wd);
        check32({nm, "_rd"}, readdata, exp_rd);
        check1({nm, "_irq"}, irq, exp_irq);
        $display("%s in=%h addr=%0d wr=%0b rd=%h irq=%0b", nm, inp, a, wr, readdata, irq);
    endtask

    // Called at a falling edge; holds reset across one rising edge.
    task automatic do_reset();
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        model_reset();
        #1;
        check32("reset_async_rd", readdata, 32'h0);
        check1("reset_async_irq", irq, 1'b0);
        @(posedge clk);
        #1;
        check32("reset_held_rd", readdata, 32'h0);
        check1("reset_held_irq", irq, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset applied rd=%h irq=%0b", readdata, irq);
    endtask

    typedef struct packed {
        logic [3:0]  inp;
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic [3:0] inp, input logic [1:0] a,
                                input logic wr, input logic [31:0] wd,
                                input logic [31:0] exp_rd, input logic exp_irq);
        vec_t v;
        v.inp = inp; v.addr = a; v.wr = wr; v.wd = wd; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    initial begin
        logic [3:0]  cur_in;
        logic [31:0] rwd;

        // Idle readback after reset.
        add(1,  4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(1,  4'hF, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
        add(1,  4'hF, 2'd1, 1'b0, 32'h0, 32'h0, 1'b0);
        add(20, 4'hF, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        add(1,  4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        // Three-cycle glitch on bit 0 is rejected.
        add(3,  4'hE, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(10, 4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(1,  4'hF, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        // Held press: DATA changes after S+D edges, readdata one later.
        add(6,  4'hE, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(1,  4'hE, 2'd0, 1'b0, 32'h0, 32'hE, 1'b0);
        add(1,  4'hE, 2'd3, 1'b0, 32'h0, 32'h1, 1'b0);
        // Mask raises irq, W1C drops it, release gives no falling event.
        add(1,  4'hE, 2'd2, 1'b1, 32'h1, 32'h0, 1'b1);
        add(1,  4'hE, 2'd2, 1'b0, 32'h0, 32'h1, 1'b1);
        add(1,  4'hE, 2'd3, 1'b1, 32'hFFFF_FFF1, 32'h1, 1'b0);
        add(1,  4'hE, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        add(10, 4'hF, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        add(1,  4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        // Bit 2 falls in the same cycle as a clear of bit 2: event wins.
        add(6,  4'hB, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(1,  4'hB, 2'd3, 1'b1, 32'h4, 32'h0, 1'b0);
        add(1,  4'hB, 2'd3, 1'b0, 32'h0, 32'h4, 1'b0);
        add(1,  4'hB, 2'd2, 1'b1, 32'h4, 32'h1, 1'b1);
        add(1,  4'hB, 2'd3, 1'b1, 32'h4, 32'h4, 1'b0);
        add(1,  4'hB, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        add(6,  4'hF, 2'd0, 1'b0, 32'h0, 32'hB, 1'b0);
        add(2,  4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);

        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        model_reset();
        #1;
        check32("por_rd", readdata, 32'h0);
        check1("por_irq", irq, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cyc_chk($sformatf("vec%0d", i), tbl[i].inp, tbl[i].addr, tbl[i].wr,
                    tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_irq);
        end

        // Reset while bit 1 is two counts into its debounce window.
        for (int k = 0; k < 4; k++) cyc_chk($sformatf("pre_rst%0d", k), 4'hD, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        do_reset();
        cyc_chk("post_rst_mask", 4'hD, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
        cyc_chk("post_rst_cap",  4'hD, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) cyc_chk($sformatf("post_rst_wait%0d", k), 4'hD, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        cyc_chk("post_rst_accept", 4'hD, 2'd0, 1'b0, 32'h0, 32'hD, 1'b0);
        cyc_chk("post_rst_edge",   4'hD, 2'd3, 1'b0, 32'h0, 32'h2, 1'b0);

        // Random traffic against the model.
        cur_in = 4'hD;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 5) == 0) cur_in = 4'($urandom);
                rwd = $urandom;
                cycle(cur_in, 2'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) != 0), rwd);
                $display("rnd%0d in=%h addr=%0d cs=%0b wn=%0b rd=%h irq=%0b",
                         n, in_port, address, chipselect, write_n, readdata, irq);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
